// File: rtl/lt_pkg.sv
// Shared types and defaults for the signed-minimum reducer.
package lt_pkg;

   localparam int unsigned LT_DEFAULT_WIDTH     = 64;
   localparam int unsigned LT_DEFAULT_IDX_WIDTH = 16;

   typedef enum logic [1:0] {
      FIRST = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } lt_min_state_e;

endpackage : lt_pkg

// File: rtl/lt_int64.sv
// Combinational signed less-than comparator: lt_o = (A < B), two's complement.
module lt_int64 #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             lt_o
);

   generate
      if (IMPL_TYPE == 0) begin : g_signed
         // Native signed compare.
         assign lt_o = $signed(A) < $signed(B);
      end else begin : g_biased
         // Flipping the sign bits maps signed order onto unsigned order.
         logic [WIDTH-1:0] a_biased;
         logic [WIDTH-1:0] b_biased;
         assign a_biased = {~A[WIDTH-1], A[WIDTH-2:0]};
         assign b_biased = {~B[WIDTH-1], B[WIDTH-2:0]};
         assign lt_o     = a_biased < b_biased;
      end
   endgenerate

endmodule : lt_int64

// File: rtl/lt_min_reduce_int64.sv
// Streaming signed-minimum reducer: returns min, first index, count and overflow per sequence.
module lt_min_reduce_int64
   import lt_pkg::*;
#(
   parameter int unsigned WIDTH     = LT_DEFAULT_WIDTH,
   parameter int unsigned IDX_WIDTH = LT_DEFAULT_IDX_WIDTH,
   parameter int unsigned IMPL_TYPE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_min,
   output logic [IDX_WIDTH-1:0] out_idx,
   output logic [IDX_WIDTH-1:0] out_count,
   output logic                 out_overflow
);

   lt_min_state_e state_q, state_d;

   logic [WIDTH-1:0]     cur_min_q, cur_min_d;
   logic [IDX_WIDTH-1:0] cur_idx_q, cur_idx_d;
   logic [IDX_WIDTH-1:0] elem_idx_q, elem_idx_d;
   logic                 ovf_q, ovf_d;

   logic [WIDTH-1:0]     out_min_q, out_min_d;
   logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;
   logic [IDX_WIDTH-1:0] out_count_q, out_count_d;
   logic                 out_ovf_q, out_ovf_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;

   logic                 accept_c;
   logic                 lt_c;

   assign accept_c = in_valid && in_ready_q;

   lt_int64 #(
      .WIDTH     (WIDTH),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_lt (
      .A    (in_data),
      .B    (cur_min_q),
      .lt_o (lt_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FIRST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FIRST:   if (accept_c) state_d = in_last ? DONE : ACCUM;
         ACCUM:   if (accept_c && in_last) state_d = DONE;
         DONE:    if (out_ready) state_d = FIRST;
         default: state_d = FIRST;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      cur_min_d   = cur_min_q;
      cur_idx_d   = cur_idx_q;
      elem_idx_d  = elem_idx_q;
      ovf_d       = ovf_q;
      out_min_d   = out_min_q;
      out_idx_d   = out_idx_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;

      if (accept_c && (state_q == FIRST)) begin
         cur_min_d  = in_data;
         cur_idx_d  = '0;
         elem_idx_d = IDX_WIDTH'(1);
         ovf_d      = 1'b0;
      end else if (accept_c && (state_q == ACCUM)) begin
         if (lt_c) begin
            cur_min_d = in_data;
            cur_idx_d = elem_idx_q;
         end
         elem_idx_d = elem_idx_q + IDX_WIDTH'(1);
         // elem_idx is never 0 in ACCUM until it has wrapped, so a zero index
         // means this element is beyond 2^IDX_WIDTH; exactly 2^IDX_WIDTH stays clean.
         if (elem_idx_q == '0) ovf_d = 1'b1;
      end

      if (accept_c && in_last) begin
         out_min_d   = cur_min_d;
         out_idx_d   = cur_idx_d;
         out_count_d = elem_idx_d;
         out_ovf_d   = ovf_d;
      end

      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d != DONE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_min_q   <= '0;
         cur_idx_q   <= '0;
         elem_idx_q  <= '0;
         ovf_q       <= 1'b0;
         out_min_q   <= '0;
         out_idx_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         cur_min_q   <= cur_min_d;
         cur_idx_q   <= cur_idx_d;
         elem_idx_q  <= elem_idx_d;
         ovf_q       <= ovf_d;
         out_min_q   <= out_min_d;
         out_idx_q   <= out_idx_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_min      = out_min_q;
   assign out_idx      = out_idx_q;
   assign out_count    = out_count_q;
   assign out_overflow = out_ovf_q;

endmodule : lt_min_reduce_int64
